cms_ctrl_writer: RTL and testbench
==================================

CMS_CTRL_WRITER -- requirements
Module: cms_ctrl_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the command buffer depth; it SHALL be a power of two, 2..16.
REQ-002 The block SHALL have parameter WRITE_GAP_CYCLES, default 1, giving the idle cycles forced between consecutive writes (0..15).
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_addr  input  CTRL_ADDR_WIDTH  target control register address.
REQ-008 cmd_data  input  CTRL_DATA_WIDTH  value to write.
REQ-009 ctrl_addr  output  CTRL_ADDR_WIDTH  address to the monitoring system control port.
REQ-010 ctrl_data  output  CTRL_DATA_WIDTH  data to the monitoring system control port.
REQ-011 ctrl_write_enable  output  1  one-cycle write strobe.
REQ-012 busy  output  1  high while the FIFO is not empty or the FSM is not IDLE.
REQ-013 addr_error  output  1  sticky illegal-address flag.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high, and pushed into the FIFO.
REQ-015 cmd_ready SHALL equal not-full, with no combinational dependence on cmd_valid and no push-while-full bypass, even when a pop occurs in the same cycle.
REQ-016 The FSM SHALL have three states: IDLE, WRITE and GAP.
REQ-017 IDLE SHALL go to WRITE when the FIFO is non-empty, popping the head into registered ctrl_addr and ctrl_data.
REQ-018 WRITE SHALL last exactly one cycle with ctrl_write_enable high.
REQ-019 WRITE SHALL go to GAP when WRITE_GAP_CYCLES>0; otherwise it SHALL go to WRITE if the FIFO is non-empty, else to IDLE.
REQ-020 GAP SHALL load a counter with WRITE_GAP_CYCLES-1 and decrement it each cycle; on reaching 0 it SHALL go to WRITE if the FIFO is non-empty, else to IDLE.
REQ-021 Latency: for a command accepted at edge k into an empty FIFO with the FSM in IDLE, ctrl_write_enable SHALL be high from edge k+2 to edge k+3.
REQ-022 Commands SHALL be issued in acceptance order, with no loss or duplication.
REQ-023 ctrl_addr and ctrl_data SHALL hold their last values when ctrl_write_enable is low.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit distinguishing full from empty.
REQ-025 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.

Reset
REQ-026 While RST_N is low at a rising edge, the block SHALL empty the FIFO and force the FSM to IDLE.
REQ-027 During that reset, ctrl_write_enable, ctrl_addr, ctrl_data, busy and addr_error SHALL all be set to 0, and cmd_ready SHALL read 1 from the first cycle after reset.
REQ-028 A reset during WRITE or GAP SHALL discard all queued commands, and no strobe SHALL occur in the cycle after the reset edge.

Configuration
REQ-029 With macro CMS_CTRL_ADDR_CHECK_EN defined, an accepted command with cmd_addr greater than WFI_REACHED SHALL be consumed but not queued, and SHALL set addr_error until reset.
REQ-030 Without CMS_CTRL_ADDR_CHECK_EN, every accepted command SHALL be queued and issued, and addr_error SHALL be tied to 0.

Structure
REQ-031 CTRL_ADDR_WIDTH, CTRL_DATA_WIDTH and ctrl_addr_t SHALL be taken from continuous_monitoring_system_pkg.
REQ-032 The FSM state enum SHALL be added to continuous_monitoring_system_pkg as cms_ctrl_writer_state_t.
REQ-033 The FIFO SHALL be a sub-module, cms_ctrl_fifo, parameterised by width (CTRL_ADDR_WIDTH+CTRL_DATA_WIDTH) and depth.

Verification
REQ-034 Single write, GAP=1: push addr 2, data 64'h8000_0000 at edge 10 -> ctrl_write_enable high only at edge 12 with ctrl_addr=2 and ctrl_data=64'h8000_0000; busy low from edge 13.
REQ-035 Back-to-back, GAP=1: push addrs 0,1,2,3 on consecutive edges -> strobes at edges 12,14,16,18 in order; cmd_ready never low.
REQ-036 Full FIFO: hold cmd_valid for 8 commands with GAP=3 -> cmd_ready low once occupancy reaches 4, and all 8 commands are issued in order with no duplication.
REQ-037 Illegal address, macro defined: push addr 9 then addr 8 -> a single strobe carrying addr 8, addr_error=1 sticky; with the macro undefined -> two strobes and addr_error=0.
REQ-038 Reset mid-operation: 3 commands queued, RST_N low for one edge during WRITE -> no strobe afterwards, busy=0, cmd_ready=1, and all outputs 0.
REQ-039 GAP=0: push 2 commands on consecutive edges -> strobes on 2 consecutive cycles.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// -----------------------------------------------------------------------------
// continuous_monitoring_system_pkg
// Shared types and constants for the continuous monitoring system control path.
//   CTRL_ADDR_WIDTH / CTRL_DATA_WIDTH : control port bus widths
//   ctrl_addr_t / ctrl_data_t          : control port address / data types
//   ctrl_cmd_t                         : one queued write command {addr, data}
//   WFI_REACHED                        : highest legal control register address
//   cms_ctrl_writer_state_t            : state encoding of cms_ctrl_writer
// -----------------------------------------------------------------------------
package continuous_monitoring_system_pkg;

   localparam int CTRL_ADDR_WIDTH = 4;
   localparam int CTRL_DATA_WIDTH = 64;
   localparam int CTRL_CMD_WIDTH  = CTRL_ADDR_WIDTH + CTRL_DATA_WIDTH;

   typedef logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_t;
   typedef logic [CTRL_DATA_WIDTH-1:0] ctrl_data_t;

   // last register of the map; anything above it does not exist
   localparam ctrl_addr_t WFI_REACHED = 4'd8;

   typedef struct packed {
      ctrl_addr_t addr;
      ctrl_data_t data;
   } ctrl_cmd_t;

   typedef enum logic [1:0] {
      CW_IDLE  = 2'd0,
      CW_WRITE = 2'd1,
      CW_GAP   = 2'd2
   } cms_ctrl_writer_state_t;

   function automatic logic ctrl_addr_legal(input ctrl_addr_t addr);
      return addr <= WFI_REACHED;
   endfunction

endpackage

// File: rtl/cms_ctrl_writer_if.sv
// -----------------------------------------------------------------------------
// cms_ctrl_writer_if
// Host command channel plus monitoring-system control port of cms_ctrl_writer.
//   master : host / environment side (drives commands, observes control port)
//   slave  : cms_ctrl_writer side
// Signals: cmd_valid, cmd_ready, cmd_addr, cmd_data,
//          ctrl_addr, ctrl_data, ctrl_write_enable, busy, addr_error
// -----------------------------------------------------------------------------
interface cms_ctrl_writer_if;
   import continuous_monitoring_system_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   ctrl_addr_t cmd_addr;
   ctrl_data_t cmd_data;
   ctrl_addr_t ctrl_addr;
   ctrl_data_t ctrl_data;
   logic       ctrl_write_enable;
   logic       busy;
   logic       addr_error;

   modport master (
      output cmd_valid, cmd_addr, cmd_data,
      input  cmd_ready, ctrl_addr, ctrl_data, ctrl_write_enable, busy, addr_error
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_data,
      output cmd_ready, ctrl_addr, ctrl_data, ctrl_write_enable, busy, addr_error
   );

endinterface

// File: rtl/cms_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// cms_ctrl_fifo
// Synchronous command FIFO, first-word-fall-through read (pop_data shows head).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   CLK, RST_N      : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : write request (ignored while full, no bypass)
//   pop, pop_data   : read request (ignored while empty), head entry
//   full, empty     : status
//   count           : current occupancy 0..DEPTH
// Parameters: WIDTH entry width, DEPTH power of two 2..16.
// -----------------------------------------------------------------------------
module cms_ctrl_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // storage needs no reset: contents are only visible through valid pointers
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/cms_ctrl_writer.sv
// -----------------------------------------------------------------------------
// cms_ctrl_writer
// Queues host write commands and replays them onto the monitoring-system
// control port as one-cycle strobes separated by WRITE_GAP_CYCLES idle cycles.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset (flushes queue, FSM to IDLE)
//   bus   : cms_ctrl_writer_if.slave
//           cmd_valid/cmd_ready/cmd_addr/cmd_data  host command channel
//           ctrl_addr/ctrl_data/ctrl_write_enable  control port (registered)
//           busy                                   queue non-empty or FSM active
//           addr_error                             sticky illegal-address flag
// Parameters: FIFO_DEPTH (power of two, 2..16), WRITE_GAP_CYCLES (0..15).
// Build option: CMS_CTRL_ADDR_CHECK_EN drops commands addressed above
// WFI_REACHED and raises addr_error; without it addr_error is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CW_IDLE  | queue empty, waiting for a command
// CW_WRITE | pop head into ctrl_addr/ctrl_data, strobe asserted next cycle
// CW_GAP   | enforced idle gap, down-counter running to terminal count 0
// -----------------------------------------------------------------------------
module cms_ctrl_writer
   import continuous_monitoring_system_pkg::*;
#(
   parameter int FIFO_DEPTH       = 4,
   parameter int WRITE_GAP_CYCLES = 1
) (
   input logic              CLK,
   input logic              RST_N,
   cms_ctrl_writer_if.slave bus
);

   localparam int             CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam bit             HAS_GAP  = (WRITE_GAP_CYCLES > 0);
   localparam logic [3:0]     GAP_LOAD = (WRITE_GAP_CYCLES > 0) ?
                                         4'(WRITE_GAP_CYCLES - 1) : 4'd0;

   cms_ctrl_writer_state_t state;
   cms_ctrl_writer_state_t state_nxt;

   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   ctrl_cmd_t        push_cmd;
   ctrl_cmd_t        head_cmd;
   logic             accept;
   logic             push_en;
   logic             pop_en;
   logic             gap_load;
   logic             more_queued;
   logic [3:0]       gap_cnt;

   ctrl_addr_t       ctrl_addr_q;
   ctrl_data_t       ctrl_data_q;
   logic             ctrl_we_q;

   // ready depends on fullness only; a pop in the same cycle does not help
   assign bus.cmd_ready = !fifo_full;
   assign accept        = bus.cmd_valid && !fifo_full;
   assign push_cmd      = {bus.cmd_addr, bus.cmd_data};

`ifdef CMS_CTRL_ADDR_CHECK_EN
   logic addr_bad;
   logic addr_error_q;

   assign addr_bad = !ctrl_addr_legal(bus.cmd_addr);
   assign push_en  = accept && !addr_bad;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         addr_error_q <= 1'b0;
      end else if (accept && addr_bad) begin
         addr_error_q <= 1'b1;
      end
   end

   assign bus.addr_error = addr_error_q;
`else
   assign push_en        = accept;
   assign bus.addr_error = 1'b0;
`endif

   cms_ctrl_fifo #(
      .WIDTH (CTRL_CMD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push_en),
      .push_data (push_cmd),
      .pop       (pop_en),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // queue still holds something after the pop happening this cycle
   assign more_queued = (fifo_count > CNT_ONE) || push_en;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= CW_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CW_IDLE: begin
            if (!fifo_empty) state_nxt = CW_WRITE;
         end
         CW_WRITE: begin
            if (HAS_GAP)          state_nxt = CW_GAP;
            else if (more_queued) state_nxt = CW_WRITE;
            else                  state_nxt = CW_IDLE;
         end
         CW_GAP: begin
            if (gap_cnt == 4'd0) state_nxt = fifo_empty ? CW_IDLE : CW_WRITE;
         end
         default: state_nxt = CW_IDLE;
      endcase
   end

   always_comb begin
      pop_en   = 1'b0;
      gap_load = 1'b0;
      case (state)
         CW_WRITE: begin
            pop_en   = !fifo_empty;
            gap_load = HAS_GAP;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         gap_cnt <= 4'd0;
      end else if (gap_load) begin
         gap_cnt <= GAP_LOAD;
      end else if ((state == CW_GAP) && (gap_cnt != 4'd0)) begin
         gap_cnt <= gap_cnt - 4'd1;
      end
   end

   // strobe is registered together with the popped entry so address and data
   // are stable for the whole strobe cycle and hold afterwards
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ctrl_addr_q <= '0;
         ctrl_data_q <= '0;
         ctrl_we_q   <= 1'b0;
      end else begin
         ctrl_we_q <= pop_en;
         if (pop_en) begin
            ctrl_addr_q <= head_cmd.addr;
            ctrl_data_q <= head_cmd.data;
         end
      end
   end

   assign bus.ctrl_addr         = ctrl_addr_q;
   assign bus.ctrl_data         = ctrl_data_q;
   assign bus.ctrl_write_enable = ctrl_we_q;
   assign bus.busy              = !fifo_empty || (state != CW_IDLE);

endmodule

// File: tb/tb_cms_ctrl_writer.sv
// -----------------------------------------------------------------------------
// tb_cms_ctrl_writer
// Three instances share clock and reset: gap 1, gap 3 and gap 0.
// Issued strobes are checked against a per-instance queue of expected commands.
// -----------------------------------------------------------------------------
module tb_cms_ctrl_writer;
   import continuous_monitoring_system_pkg::*;

   localparam int G1 = 0;
   localparam int G3 = 1;
   localparam int G0 = 2;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   cms_ctrl_writer_if bus_a ();
   cms_ctrl_writer_if bus_b ();
   cms_ctrl_writer_if bus_c ();

   cms_ctrl_writer #(.FIFO_DEPTH(4), .WRITE_GAP_CYCLES(1)) dut_g1 (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
   cms_ctrl_writer #(.FIFO_DEPTH(4), .WRITE_GAP_CYCLES(3)) dut_g3 (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));
   cms_ctrl_writer #(.FIFO_DEPTH(4), .WRITE_GAP_CYCLES(0)) dut_g0 (.CLK(CLK), .RST_N(RST_N), .bus(bus_c));

   logic       drv_valid [3];
   ctrl_addr_t drv_addr  [3];
   ctrl_data_t drv_data  [3];
   logic       o_ready [3];
   logic       o_we    [3];
   logic       o_busy  [3];
   logic       o_err   [3];
   ctrl_addr_t o_addr  [3];
   ctrl_data_t o_data  [3];

   assign bus_a.cmd_valid = drv_valid[0];
   assign bus_a.cmd_addr  = drv_addr[0];
   assign bus_a.cmd_data  = drv_data[0];
   assign bus_b.cmd_valid = drv_valid[1];
   assign bus_b.cmd_addr  = drv_addr[1];
   assign bus_b.cmd_data  = drv_data[1];
   assign bus_c.cmd_valid = drv_valid[2];
   assign bus_c.cmd_addr  = drv_addr[2];
   assign bus_c.cmd_data  = drv_data[2];

   assign o_ready[0] = bus_a.cmd_ready;
   assign o_we[0]    = bus_a.ctrl_write_enable;
   assign o_busy[0]  = bus_a.busy;
   assign o_err[0]   = bus_a.addr_error;
   assign o_addr[0]  = bus_a.ctrl_addr;
   assign o_data[0]  = bus_a.ctrl_data;
   assign o_ready[1] = bus_b.cmd_ready;
   assign o_we[1]    = bus_b.ctrl_write_enable;
   assign o_busy[1]  = bus_b.busy;
   assign o_err[1]   = bus_b.addr_error;
   assign o_addr[1]  = bus_b.ctrl_addr;
   assign o_data[1]  = bus_b.ctrl_data;
   assign o_ready[2] = bus_c.cmd_ready;
   assign o_we[2]    = bus_c.ctrl_write_enable;
   assign o_busy[2]  = bus_c.busy;
   assign o_err[2]   = bus_c.addr_error;
   assign o_addr[2]  = bus_c.ctrl_addr;
   assign o_data[2]  = bus_c.ctrl_data;

   ctrl_cmd_t exp_q      [3][$];
   int        strobe_cyc [3][$];
   int        n_cmp = 0;
   int        n_bad = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic bit legal(input ctrl_addr_t a);
`ifdef CMS_CTRL_ADDR_CHECK_EN
      return a <= 4'd8;
`else
      return 1'b1;
`endif
   endfunction

   // scoreboard: every strobe must match the oldest outstanding command
   always @(negedge CLK) begin
      for (int i = 0; i < 3; i++) begin
         if (o_we[i] === 1'b1) begin
            strobe_cyc[i].push_back(cyc);
            if (exp_q[i].size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe dut%0d: got addr %0h data %0h, required no strobe (cycle %0d)",
                        i, o_addr[i], o_data[i], cyc);
            end else begin
               ctrl_cmd_t e;
               e = exp_q[i].pop_front();
               chk($sformatf("strobe_addr_dut%0d", i), 64'(o_addr[i]), 64'(e.addr));
               chk($sformatf("strobe_data_dut%0d", i), o_data[i], e.data);
            end
         end
      end
   end

   // drives one command for one edge, starting and ending on a falling edge
   task automatic send(input int d, input ctrl_addr_t a, input ctrl_data_t v, input bit issue);
      drv_valid[d] = 1'b1;
      drv_addr[d]  = a;
      drv_data[d]  = v;
      if (issue) exp_q[d].push_back(ctrl_cmd_t'{addr: a, data: v});
      @(negedge CLK);
      drv_valid[d] = 1'b0;
   endtask

   typedef struct {
      ctrl_addr_t addr;
      ctrl_data_t data;
      bit         exp_issue;
      bit         exp_err;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_addr_t last_addr;
      ctrl_data_t last_data;
      bit         err_run;
      int         k0;

      for (int i = 0; i < 3; i++) begin
         drv_valid[i] = 1'b0;
         drv_addr[i]  = '0;
         drv_data[i]  = '0;
      end

      // table: inputs and expected outcome (issue, sticky error after it)
      vecs[0] = '{addr: 4'd2,  data: 64'h0000_0000_8000_0000, exp_issue: 1'b0, exp_err: 1'b0};
      vecs[1] = '{addr: 4'd0,  data: 64'h0000_0000_0000_0000, exp_issue: 1'b0, exp_err: 1'b0};
      vecs[2] = '{addr: 4'd15, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_issue: 1'b0, exp_err: 1'b0};
      vecs[3] = '{addr: 4'd8,  data: 64'hA5A5_5A5A_0F0F_F0F0, exp_issue: 1'b0, exp_err: 1'b0};
      vecs[4] = '{addr: 4'd9,  data: 64'h0000_0000_0000_1234, exp_issue: 1'b0, exp_err: 1'b0};
      vecs[5] = '{addr: 4'd1,  data: 64'hDEAD_BEEF_CAFE_F00D, exp_issue: 1'b0, exp_err: 1'b0};
      err_run = !legal(4'd9);
      for (int i = 0; i < 6; i++) begin
         vecs[i].exp_issue = legal(vecs[i].addr);
         err_run           = err_run | !legal(vecs[i].addr);
         vecs[i].exp_err   = err_run;
      end

      // reset values
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_we_dut%0d", i),   64'(o_we[i]),   64'd0);
         chk($sformatf("rst_addr_dut%0d", i), 64'(o_addr[i]), 64'd0);
         chk($sformatf("rst_data_dut%0d", i), o_data[i],      64'd0);
         chk($sformatf("rst_busy_dut%0d", i), 64'(o_busy[i]), 64'd0);
         chk($sformatf("rst_err_dut%0d", i),  64'(o_err[i]),  64'd0);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_ready_dut%0d", i), 64'(o_ready[i]), 64'd1);

      // illegal address then legal address
      strobe_cyc[G1].delete();
      chk("ill_err_before", 64'(o_err[G1]), 64'd0);
      send(G1, 4'd9, 64'h99, legal(4'd9));
      send(G1, 4'd8, 64'h88, 1'b1);
      repeat (6) @(negedge CLK);
      chk("ill_strobe_count", 64'(strobe_cyc[G1].size()), legal(4'd9) ? 64'd2 : 64'd1);
      chk("ill_err_after", 64'(o_err[G1]), 64'(!legal(4'd9)));
      last_addr = 4'd8;
      last_data = 64'h88;

      // table: single command each, latency / hold / busy / sticky error
      for (int v = 0; v < 6; v++) begin
         chk($sformatf("vec%0d_ready", v), 64'(o_ready[G1]), 64'd1);
         send(G1, vecs[v].addr, vecs[v].data, vecs[v].exp_issue);
         if (vecs[v].exp_issue) begin
            last_addr = vecs[v].addr;
            last_data = vecs[v].data;
         end
         for (int j = 1; j <= 3; j++) begin
            @(negedge CLK);
            chk($sformatf("vec%0d_we_e%0d", v, j), 64'(o_we[G1]), 64'(vecs[v].exp_issue && (j == 2)));
            if (j == 1) chk($sformatf("vec%0d_busy_e1", v), 64'(o_busy[G1]), 64'(vecs[v].exp_issue));
         end
         chk($sformatf("vec%0d_busy_done", v), 64'(o_busy[G1]), 64'd0);
         chk($sformatf("vec%0d_addr_hold", v), 64'(o_addr[G1]), 64'(last_addr));
         chk($sformatf("vec%0d_data_hold", v), o_data[G1], last_data);
         chk($sformatf("vec%0d_err", v), 64'(o_err[G1]), 64'(vecs[v].exp_err));
      end

      // back-to-back with gap 1: strobes every second edge
      strobe_cyc[G1].delete();
      k0 = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_ready%0d", i), 64'(o_ready[G1]), 64'd1);
         send(G1, ctrl_addr_t'(i), 64'hB000 + 64'(i), 1'b1);
         if (i == 0) k0 = cyc;
      end
      repeat (10) @(negedge CLK);
      chk("b2b_count", 64'(strobe_cyc[G1].size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("b2b_edge%0d", i),
             64'((i < strobe_cyc[G1].size()) ? strobe_cyc[G1][i] : -1), 64'(k0 + 2 + 2 * i));

      // fill with gap 3: ready must track an occupancy model
      begin
         int acc, iss;
         bit drove, rdy_prev, saw_low;
         acc = 0; iss = 0; drove = 0; rdy_prev = 0; saw_low = 0;
         strobe_cyc[G3].delete();
         for (int t = 0; t < 80 && !(acc == 8 && iss == 8); t++) begin
            if (drove && rdy_prev) begin
               exp_q[G3].push_back(ctrl_cmd_t'{addr: ctrl_addr_t'(acc), data: 64'hF00 + 64'(acc)});
               acc++;
            end
            if (o_we[G3] === 1'b1) iss++;
            chk("full_ready", 64'(o_ready[G3]), 64'((acc - iss) < 4));
            if (o_ready[G3] === 1'b0) saw_low = 1'b1;
            if (acc < 8) begin
               drv_valid[G3] = 1'b1;
               drv_addr[G3]  = ctrl_addr_t'(acc);
               drv_data[G3]  = 64'hF00 + 64'(acc);
               drove = 1'b1;
            end else begin
               drv_valid[G3] = 1'b0;
               drove = 1'b0;
            end
            rdy_prev = o_ready[G3];
            @(negedge CLK);
         end
         drv_valid[G3] = 1'b0;
         chk("full_accepted", 64'(acc), 64'd8);
         chk("full_issued", 64'(iss), 64'd8);
         chk("full_saw_not_ready", 64'(saw_low), 64'd1);
         @(negedge CLK);
         for (int i = 1; i < 8; i++)
            chk($sformatf("full_spacing%0d", i),
                64'((i < strobe_cyc[G3].size()) ? strobe_cyc[G3][i] - strobe_cyc[G3][i-1] : -1), 64'd4);
      end

      // gap 0: consecutive strobes
      strobe_cyc[G0].delete();
      send(G0, 4'd3, 64'h33, 1'b1);
      k0 = cyc;
      send(G0, 4'd4, 64'h44, 1'b1);
      repeat (6) @(negedge CLK);
      chk("gap0_count", 64'(strobe_cyc[G0].size()), 64'd2);
      chk("gap0_first", 64'((strobe_cyc[G0].size() > 0) ? strobe_cyc[G0][0] : -1), 64'(k0 + 2));
      chk("gap0_second", 64'((strobe_cyc[G0].size() > 1) ? strobe_cyc[G0][1] : -1), 64'(k0 + 3));

      // reset while WRITE with commands still queued
      strobe_cyc[G1].delete();
      send(G1, 4'd5, 64'h5555, 1'b1);
      k0 = cyc;
      send(G1, 4'd6, 64'h6666, 1'b0);
      send(G1, 4'd7, 64'h7777, 1'b0);
      @(negedge CLK);
      chk("mid_busy", 64'(o_busy[G1]), 64'd1);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      chk("mid_we", 64'(o_we[G1]), 64'd0);
      chk("mid_busy_rst", 64'(o_busy[G1]), 64'd0);
      chk("mid_ready", 64'(o_ready[G1]), 64'd1);
      chk("mid_addr", 64'(o_addr[G1]), 64'd0);
      chk("mid_data", o_data[G1], 64'd0);
      chk("mid_err", 64'(o_err[G1]), 64'd0);
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         chk($sformatf("mid_quiet%0d", j), 64'(o_we[G1]), 64'd0);
      end
      chk("mid_strobe_count", 64'(strobe_cyc[G1].size()), 64'd1);
      chk("mid_strobe_edge", 64'((strobe_cyc[G1].size() > 0) ? strobe_cyc[G1][0] : -1), 64'(k0 + 2));

      for (int i = 0; i < 3; i++)
         chk($sformatf("drained_dut%0d", i), 64'(exp_q[i].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
